// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | arb_pkg: shared defaults, state encoding and quantum helper for the  |
// | weighted round-robin arbiter.            Revision: 1.0               |
// +----------------------------------------------------------------------+
package arb_pkg;

  localparam int DEF_N  = 4;
  localparam int DEF_WW = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // A zero weight still earns one grant cycle so no requester can be starved.
  function automatic logic [31:0] eff_quantum(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick: combinational rotating priority encoder, lowest index at or |
// | after start wins, wrapping past N-1.     Revision: 1.0               |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           found,
  output logic [IDW-1:0] idx,
  output logic [N-1:0]   onehot
);

  logic [2*N-1:0] w_masked;
  logic [IDW:0]   w_sel;

  // Upper copy of req catches winners that lie below start after wrapping.
  assign w_masked = {req, req} & ({(2*N){1'b1}} << start);

  always_comb begin
    found = 1'b0;
    w_sel = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (w_masked[i]) begin
        found = 1'b1;
        w_sel = (IDW+1)'(i);
      end
    end
    if (w_sel >= (IDW+1)'(N)) idx = IDW'(w_sel - (IDW+1)'(N));
    else                      idx = IDW'(w_sel);
    onehot = found ? (N'(1) << idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wrr_arbiter: N-way weighted round-robin arbiter with registered      |
// | one-hot grant and early release.         Revision: 1.0               |
// +----------------------------------------------------------------------+
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int WW  = DEF_WW,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDW-1:0]  grant_id
);

  state_t         r_state, w_state_nxt;
  logic [IDW-1:0] r_holder, w_holder_nxt;
  logic [WW:0]    r_count, w_count_nxt;
  logic [WW:0]    r_quantum, w_quantum_nxt;
  logic [IDW-1:0] r_ptr, w_ptr_nxt;
  logic [N-1:0]   r_grant, w_grant_nxt;

  logic           w_keep;
  logic [IDW-1:0] w_start;
  logic           w_found;
  logic [IDW-1:0] w_idx;
  logic [N-1:0]   w_onehot;
  logic [WW-1:0]  w_wsel;

  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] x);
    return (x == IDW'(N-1)) ? '0 : x + IDW'(1);
  endfunction

  assign w_keep  = (r_state == GRANT) && req[r_holder] && (r_count < r_quantum);
  assign w_start = (r_state == GRANT) ? inc_wrap(r_holder) : r_ptr;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (req),
    .start  (w_start),
    .found  (w_found),
    .idx    (w_idx),
    .onehot (w_onehot)
  );

  always_comb begin
    w_wsel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_idx == IDW'(i)) w_wsel = weight[i*WW +: WW];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_holder_nxt  = r_holder;
    w_count_nxt   = r_count;
    w_quantum_nxt = r_quantum;
    w_ptr_nxt     = r_ptr;
    w_grant_nxt   = r_grant;
    if (w_keep) begin
      w_count_nxt = r_count + (WW+1)'(1);
    end else if (w_found) begin
      w_state_nxt   = GRANT;
      w_holder_nxt  = w_idx;
      w_grant_nxt   = w_onehot;
      w_count_nxt   = (WW+1)'(1);
      w_quantum_nxt = (WW+1)'(eff_quantum(32'(w_wsel)));
      w_ptr_nxt     = inc_wrap(w_idx);
    end else begin
      // ptr already points past the last holder, so it is left alone here.
      w_state_nxt = IDLE;
      w_grant_nxt = '0;
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_holder  <= '0;
      r_count   <= '0;
      r_quantum <= '0;
      r_ptr     <= '0;
      r_grant   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_holder  <= w_holder_nxt;
      r_count   <= w_count_nxt;
      r_quantum <= w_quantum_nxt;
      r_ptr     <= w_ptr_nxt;
      r_grant   <= w_grant_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = |r_grant;
  assign grant_id    = (r_state == GRANT) ? r_holder : '0;

endmodule
`default_nettype wire

// File: tb/tb_wrr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wrr_arbiter: scenario tasks plus randomized run against a         |
// | behavioural arbiter model.               Revision: 1.0               |
// +----------------------------------------------------------------------+
module tb_wrr_arbiter;

  localparam int N   = 4;
  localparam int WW  = 4;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*WW-1:0] weight = '0;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDW-1:0]  grant_id;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit m_valid;
  int m_holder, m_cnt, m_quant, m_ptr;

  wrr_arbiter #(.N(N), .WW(WW), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .weight      (weight),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  function automatic int wfield(input logic [N*WW-1:0] w, input int i);
    int v;
    v = int'(w[i*WW +: WW]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic logic [N-1:0] m_grant();
    return m_valid ? (N'(1) << m_holder) : '0;
  endfunction

  function automatic logic [IDW-1:0] m_id();
    return m_valid ? IDW'(m_holder) : '0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_holder = 0; m_cnt = 0; m_quant = 0; m_ptr = 0;
  endtask

  task automatic model_edge();
    int s, win;
    bit found;
    if (m_valid && req[m_holder] && m_cnt < m_quant) begin
      m_cnt++;
    end else begin
      s = m_valid ? (m_holder + 1) % N : m_ptr;
      found = 0;
      win = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(s + k) % N]) begin
          found = 1;
          win = (s + k) % N;
        end
      end
      if (found) begin
        m_valid = 1; m_holder = win; m_cnt = 1;
        m_quant = wfield(weight, win);
        m_ptr = (win + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N*WW-1:0] w);
    @(negedge clk);
    req = r;
    weight = w;
  endtask

  // Leaves rst released at a negedge with the given inputs applied.
  task automatic do_reset(input logic [N-1:0] r, input logic [N*WW-1:0] w);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    req = r;
    weight = w;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    weight = 16'h1111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want %b", grant, 4'b0000); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", grant_id); end
    @(negedge clk);
    rst = 1'b0;
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want %b", grant, 4'b0001); end
    step();
    // asynchronous assertion between edges
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    total++; if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      bad++; $display("FAIL reset_async: got grant=%b valid=%b want 0000/0", grant, grant_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL reset_rearm: got %b want %b", grant, 4'b0001); end
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset(4'b1111, 16'h1111);
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (grant !== exp_g[i] || grant_id !== IDW'(i % 4)) begin
        bad++; $display("FAIL rotation[%0d]: got %b id %0d want %b id %0d", i, grant, grant_id, exp_g[i], i % 4);
      end
    end
  endtask

  task automatic test_weighted();
    int seq [7] = '{0, 0, 1, 2, 2, 2, 3};
    logic [N-1:0] e;
    do_reset(4'b1111, 16'h0312);
    for (int i = 0; i < 14; i++) begin
      step();
      e = N'(1) << seq[i % 7];
      total++; if (grant !== e) begin
        bad++; $display("FAIL weighted[%0d]: got %b want %b", i, grant, e);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset(4'b0011, 16'h1124);
    step();
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL early_hold: got %b want %b", grant, 4'b0001); end
    drive(4'b0010, 16'h1124);
    step();
    total++; if (grant !== 4'b0010 || grant_valid !== 1'b1) begin
      bad++; $display("FAIL early_handover: got %b valid %b want 0010/1", grant, grant_valid);
    end
    step();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL early_quantum: got %b want %b", grant, 4'b0010); end
  endtask

  task automatic test_sole();
    do_reset(4'b0100, 16'h0311);
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (grant !== 4'b0100 || grant_id !== 2'd2) begin
        bad++; $display("FAIL sole[%0d]: got %b id %0d want 0100 id 2", i, grant, grant_id);
      end
    end
  endtask

  task automatic test_idle_wrap();
    do_reset(4'b1000, 16'h1111);
    step();
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL wrap_holder3: got %b want %b", grant, 4'b1000); end
    drive(4'b0000, 16'h1111);
    step();
    total++; if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      bad++; $display("FAIL wrap_idle: got %b valid %b id %0d want 0000/0/0", grant, grant_valid, grant_id);
    end
    drive(4'b1001, 16'h1111);
    step();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL wrap_ptr: got %b want %b", grant, 4'b0001); end
  endtask

  task automatic test_random();
    logic [N-1:0]    r;
    logic [N*WW-1:0] w;
    logic [N-1:0]    eg;
    do_reset(4'b0000, 16'h2131);
    r = '0;
    w = 16'h2131;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) r = N'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) w = (N*WW)'($urandom);
      drive(r, w);
      step();
      eg = m_grant();
      total++; if (grant !== eg || grant_valid !== m_valid || grant_id !== m_id()) begin
        bad++; $display("FAIL random[%0d]: got %b/%b/%0d want %b/%b/%0d", i, grant, grant_valid, grant_id, eg, m_valid, m_id());
      end
      total++; if ($countones(grant) > 1 || grant_valid !== (|grant)) begin
        bad++; $display("FAIL random_invariant[%0d]: got grant %b valid %b want onehot0 and valid==|grant", i, grant, grant_valid);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_weighted();
    test_early_release();
    test_sole();
    test_idle_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Parametrised weighted round-robin arbiter with N requesters and a registered one-hot grant.
- Each grant lasts up to a per-requester quantum of cycles, then passes to the next requester.
- Generalises the fixed 3-requester arbiter to any N, and adds per-requester weights and early release.
- Sits in front of a shared resource (bus/port) that serves one requester at a time.

Parameters:
- N, 4, number of requesters (N >= 2).
- WW, 4, width of each weight field in bits.
- IDW, $clog2(N), width of the grant index.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N  request vector; bit i = requester i wants the resource.
- weight  input  N*WW  packed quanta; bits [i*WW +: WW] = max consecutive grant cycles for requester i.
- grant  output  N  registered one-hot grant, or all zero.
- grant_valid  output  1  high when any grant bit is high.
- grant_id  output  IDW  index of the granted requester; 0 when grant_valid=0.

Behaviour:
- Reset (asynchronous, active-high):
  - grant=0, grant_valid=0, grant_id=0, holder=0, count=0, ptr=0.
  - Outputs clear immediately on rst assertion, with no clock edge needed.
  - First arbitration after reset release starts at requester 0.
- Internal state:
  - holder (IDW): currently granted requester.
  - count (WW+1): number of cycles the current grant has been asserted, starting at 1.
  - quantum (WW+1): the holder's weight, latched when its grant starts.
  - ptr (IDW): start index for the next search.
- Weight rules:
  - A weight field of 0 is treated as 1.
  - Weight is sampled only at grant start; changing it mid-grant has no effect on the current grant.
- Two states: IDLE (grant_valid=0) and GRANT (grant_valid=1). Decisions are made at each rising edge.
- Keep rule: in GRANT, if req[holder]=1 and count < quantum, keep the grant and increment count.
- Rearbitrate rule, applied in all other cases (IDLE; holder dropped req; count == quantum):
  - Search req circularly starting at ptr. In GRANT, ptr = (holder+1) mod N; in IDLE, ptr holds its last value.
  - First set bit wins: grant becomes its one-hot, grant_id its index, count=1, quantum latched, ptr = (winner+1) mod N. Next state is GRANT.
  - If no req bit is set: grant=0 and next state is IDLE.
- Latency:
  - A request first seen at edge t produces grant at edge t (visible in the cycle after t) when the arbiter is idle.
  - Handover between requesters is zero-bubble: the old grant drops and the new grant rises at the same edge.
- Sole requester with exhausted quantum: it is regranted at the same edge with count=1. grant stays high continuously.
- Holder drops req while others request: the next requester is granted at the next edge. The holder's unused quantum is discarded.
- Requests are level-sensitive, with no latching. A req pulse between edges is ignored.
- Wrap-around: the search index wraps from N-1 to 0. ptr wraps the same way.
- Invariants: grant is always zero or one-hot, and grant_valid == |grant.

Decomposition:
- Package arb_pkg holds:
  - default N and WW;
  - state enum {IDLE, GRANT};
  - a function returning the effective quantum (weight 0 maps to 1).
- Sub-module rr_pick: combinational rotating priority encoder.
  - Inputs: req, start pointer.
  - Outputs: found, index, one-hot.
  - Implemented as double-width vector masking.
  - Reusable by other arbiters.

Test Plan:
- Reset: rst=1 with req=4'b1111 -> grant=0, grant_valid=0. Assert rst mid-grant between edges -> grant drops to 0 within the same cycle. After release with all requesting -> first grant is 4'b0001.
- Rotation with unit weights: weights all 1, req=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, one per cycle, with grant_id 0,1,2,3,0.
- Weighted quanta: w0=2, w1=1, w2=3, w3=0, req=4'b1111 -> grant 0001 x2, 0010 x1, 0100 x3, 1000 x1, then repeats. Total period is 7 cycles.
- Early release: w0=4, req=4'b0011, drop req[0] after the 2nd grant cycle -> grant 0010 at the next edge with no idle cycle. Requester 1 then holds for its quantum.
- Sole requester: req=4'b0100, w2=3, held for 10 cycles -> grant=4'b0100 on every cycle with no gap. count cycles 1,2,3,1,2,3,...
- Idle and wrap: holder=3 releases with req=4'b0000 -> grant=0. Next req=4'b1001 -> grant 0001, because ptr wrapped to 0.
